// File: rtl/booth_mult_seq.sv
// Sequential signed Booth multiplier, one recoding step per clock, start/busy/done handshake.
// Define BOOTH_RADIX4_EN for radix-4 recoding (ceil(WIDTH/2) steps); default is radix-2.
module booth_mult_seq #(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [CNT_W-1:0]     cycle_count
);

`ifdef BOOTH_RADIX4_EN
    localparam int QW   = WIDTH + (WIDTH % 2);
    localparam int AW   = WIDTH + 2;
    localparam int SH   = 2;
    localparam int ITER = QW / 2;
`else
    localparam int QW   = WIDTH;
    localparam int AW   = WIDTH + 1;
    localparam int SH   = 1;
    localparam int ITER = WIDTH;
`endif
    localparam int TW = AW + QW + 1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [AW-1:0]        r_a;
    logic [AW-1:0]        r_m;
    logic [QW-1:0]        r_q;
    logic                 r_q1;
    logic [CNT_W-1:0]     r_iter;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_done;

    logic                 w_load;
    logic                 w_last;
    logic [AW-1:0]        w_addend;
    logic [AW-1:0]        w_sum;
    logic [TW-1:0]        w_shift;
    logic [AW-1:0]        w_next_a;
    logic [QW-1:0]        w_next_q;
    logic                 w_next_q1;
    logic [2*WIDTH-1:0]   w_prod;

    assign w_load = (r_state == S_IDLE) && start;
    assign w_last = (r_state == S_RUN) && (r_iter == CNT_W'(1));

`ifdef BOOTH_RADIX4_EN
    logic [AW-1:0] w_m2;
    assign w_m2 = {r_m[AW-2:0], 1'b0};

    always_comb begin
        w_addend = '0;
        case ({r_q[1:0], r_q1})
            3'b001, 3'b010: w_addend = r_m;
            3'b011:         w_addend = w_m2;
            3'b100:         w_addend = -w_m2;
            3'b101, 3'b110: w_addend = -r_m;
            default:        w_addend = '0;
        endcase
    end
`else
    always_comb begin
        w_addend = '0;
        case ({r_q[0], r_q1})
            2'b01:   w_addend = r_m;
            2'b10:   w_addend = -r_m;
            default: w_addend = '0;
        endcase
    end
`endif

    // {A,Q,Q-1} shifted as one signed word so A's sign fills the vacated bits
    assign w_sum      = r_a + w_addend;
    assign w_shift    = TW'($signed({w_sum, r_q, r_q1}) >>> SH);
    assign w_next_a   = w_shift[TW-1 -: AW];
    assign w_next_q   = w_shift[QW:1];
    assign w_next_q1  = w_shift[0];
    assign w_prod     = w_shift[2*WIDTH:1];

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_q1      <= 1'b0;
            r_iter    <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_a    <= '0;
                r_m    <= AW'($signed(multiplicand));
                r_q    <= QW'($signed(multiplier));
                r_q1   <= 1'b0;
                r_iter <= CNT_W'(ITER);
                r_cnt  <= '0;
            end else if (r_state == S_RUN) begin
                r_a    <= w_next_a;
                r_q    <= w_next_q;
                r_q1   <= w_next_q1;
                r_iter <= r_iter - CNT_W'(1);
                r_cnt  <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_product <= w_prod;
                    r_done    <= 1'b1;
                end
            end
        end
    end

    assign busy        = (r_state == S_RUN);
    assign done        = r_done;
    assign product     = r_product;
    assign cycle_count = r_cnt;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq at WIDTH 4, 5 and 8; follows BOOTH_RADIX4_EN for step counts.
module tb_booth_mult_seq;

`ifdef BOOTH_RADIX4_EN
    localparam int IT4 = 2, IT5 = 3, IT8 = 4;
`else
    localparam int IT4 = 4, IT5 = 5, IT8 = 8;
`endif

    typedef struct {
        logic [15:0] prod;
        int          cnt;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;

    logic       start4 = 1'b0, busy4, done4;
    logic [3:0] m4 = '0, q4 = '0;
    logic [7:0] p4;
    logic [2:0] c4;

    logic       start5 = 1'b0, busy5, done5;
    logic [4:0] m5 = '0, q5 = '0;
    logic [9:0] p5;
    logic [2:0] c5;

    logic        start8 = 1'b0, busy8, done8;
    logic [7:0]  m8 = '0, q8 = '0;
    logic [15:0] p8;
    logic [3:0]  c8;

    exp_t sb4[$];
    exp_t sb5[$];
    exp_t sb8[$];

    booth_mult_seq #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .multiplicand(m4), .multiplier(q4),
        .busy(busy4), .done(done4), .product(p4), .cycle_count(c4));
    booth_mult_seq #(.WIDTH(5)) u5 (
        .clk(clk), .rst(rst), .start(start5), .multiplicand(m5), .multiplier(q5),
        .busy(busy5), .done(done5), .product(p5), .cycle_count(c5));
    booth_mult_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .multiplicand(m8), .multiplier(q8),
        .busy(busy8), .done(done8), .product(p8), .cycle_count(c8));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: pop on every done pulse; a done with nothing pending is an error
    always @(negedge clk) begin : mon4
        exp_t e;
        if (done4) begin
            if (sb4.size() == 0) chk("w4 unexpected done", 32'd1, 32'd0);
            else begin
                e = sb4.pop_front();
                chk("w4 product", 32'(p4), 32'(e.prod));
                chk("w4 cycle_count", 32'(c4), 32'(e.cnt));
                chk("w4 latency", 32'(cyc - e.acc), 32'(e.cnt));
            end
        end
    end

    always @(negedge clk) begin : mon5
        exp_t e;
        if (done5) begin
            if (sb5.size() == 0) chk("w5 unexpected done", 32'd1, 32'd0);
            else begin
                e = sb5.pop_front();
                chk("w5 product", 32'(p5), 32'(e.prod));
                chk("w5 cycle_count", 32'(c5), 32'(e.cnt));
                chk("w5 latency", 32'(cyc - e.acc), 32'(e.cnt));
            end
        end
    end

    always @(negedge clk) begin : mon8
        exp_t e;
        if (done8) begin
            if (sb8.size() == 0) chk("w8 unexpected done", 32'd1, 32'd0);
            else begin
                e = sb8.pop_front();
                chk("w8 product", 32'(p8), 32'(e.prod));
                chk("w8 cycle_count", 32'(c8), 32'(e.cnt));
                chk("w8 latency", 32'(cyc - e.acc), 32'(e.cnt));
            end
        end
    end

    task automatic wait_idle(input logic b, input string name, output logic ok);
        ok = 1'b1;
    endtask

    task automatic issue4(input logic [3:0] m, input logic [3:0] q, input logic [7:0] p, input bit push);
        exp_t e;
        int n = 0;
        while (busy4 && n < 50) begin @(negedge clk); n++; end
        if (busy4) chk("w4 idle timeout", 32'd1, 32'd0);
        m4 = m; q4 = q; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        e.prod = 16'(p); e.cnt = IT4; e.acc = cyc;
        if (push) sb4.push_back(e);
    endtask

    task automatic issue5(input logic [4:0] m, input logic [4:0] q, input logic [9:0] p);
        exp_t e;
        int n = 0;
        while (busy5 && n < 50) begin @(negedge clk); n++; end
        if (busy5) chk("w5 idle timeout", 32'd1, 32'd0);
        m5 = m; q5 = q; start5 = 1'b1;
        @(posedge clk); #1;
        start5 = 1'b0;
        e.prod = 16'(p); e.cnt = IT5; e.acc = cyc;
        sb5.push_back(e);
    endtask

    task automatic issue8(input logic [7:0] m, input logic [7:0] q, input logic [15:0] p);
        exp_t e;
        int n = 0;
        while (busy8 && n < 50) begin @(negedge clk); n++; end
        if (busy8) chk("w8 idle timeout", 32'd1, 32'd0);
        m8 = m; q8 = q; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        e.prod = p; e.cnt = IT8; e.acc = cyc;
        sb8.push_back(e);
    endtask

    task automatic wait_done4();
        int n = 0;
        @(negedge clk);
        while (!done4 && n < 50) begin @(negedge clk); n++; end
        if (!done4) chk("w4 done timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb4.size() + sb5.size() + sb8.size()) != 0 && n < 200) begin
            @(negedge clk); n++;
        end
        chk("scoreboard drained", 32'(sb4.size() + sb5.size() + sb8.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset busy", 32'({busy4, busy5, busy8}), 32'd0);
        chk("reset done", 32'({done4, done5, done8}), 32'd0);
        chk("reset product w4", 32'(p4), 32'd0);
        chk("reset product w8", 32'(p8), 32'd0);
        chk("reset cycle_count", 32'({c4, c5, c8}), 32'd0);

        issue4(4'hA, 4'h6, 8'hDC, 1'b1);    // -6*6
        issue8(8'h7F, 8'h80, 16'hC080);     // 127*-128
        issue5(5'h10, 5'h10, 10'h100);      // -16*-16
        issue4(4'h8, 4'h1, 8'hF8, 1'b1);    // -8*1
        issue4(4'h8, 4'h8, 8'h40, 1'b1);    // -8*-8
        issue4(4'h7, 4'h7, 8'h31, 1'b1);
        issue4(4'h7, 4'h8, 8'hC8, 1'b1);
        issue4(4'h0, 4'hD, 8'h00, 1'b1);
        issue4(4'hF, 4'hF, 8'h01, 1'b1);
        issue4(4'h3, 4'hB, 8'hF1, 1'b1);
        issue8(8'h80, 8'h80, 16'h4000);
        issue8(8'hFF, 8'h01, 16'hFFFF);
        issue8(8'h12, 8'h34, 16'h03A8);
        issue8(8'h9C, 8'h03, 16'hFED4);
        issue5(5'h0F, 5'h10, 10'h310);
        issue5(5'h19, 5'h0B, 10'h3B3);
        issue5(5'h0D, 5'h0D, 10'h0A9);
        issue5(5'h1F, 5'h0F, 10'h3F1);
        drain();

        // A second start while busy must be ignored
        issue4(4'hA, 4'h6, 8'hDC, 1'b1);
        @(posedge clk); #1;
        m4 = 4'h7; q4 = 4'h7; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        // Start presented during the done cycle is taken immediately
        wait_done4();
        issue4(4'h3, 4'hB, 8'hF1, 1'b1);
        wait_done4();
        issue4(4'h8, 4'h8, 8'h40, 1'b1);
        drain();
        chk("w4 product held", 32'(p4), 32'h40);

        // Reset mid-operation with start high aborts without a done pulse
        issue4(4'hA, 4'h6, 8'hDC, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1; start4 = 1'b1; m4 = 4'h7; q4 = 4'h7;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy", 32'(busy4), 32'd0);
        chk("rst product", 32'(p4), 32'd0);
        chk("rst cycle_count", 32'(c4), 32'd0);
        #1 rst = 1'b0; start4 = 1'b0;
        repeat (IT4 + 3) @(negedge clk);
        chk("rst no restart", 32'(busy4), 32'd0);
        issue4(4'h7, 4'h8, 8'hC8, 1'b1);
        issue8(8'h7F, 8'h80, 16'hC080);
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: bench did not complete");
        $fatal(1);
    end

endmodule
